// File: rtl/dnn_dense_accel.sv
// dnn_dense_accel: dense-layer accelerator computing up to LANES Q16.16 neuron
// outputs per launch (out[n] = bias[n] + sum_k w[n][k]*act[k]). Operands are
// fetched over an Avalon-MM master; the Nios II configures it through an
// Avalon-MM slave. Define DNN_RELU_EN to clamp negative results to zero on
// the write-back path.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a CTRL write
// RD_BIAS | loading N biases into the lane accumulators
// RD_ACT  | fetching act[k], shared by every lane
// RD_W    | fetching w[n][k] for n = 0..N-1, one MAC per returned word
// WR_OUT  | writing N results back, lane order
// DONE    | one cycle: done set, busy clear, then back to IDLE
module dnn_dense_accel #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic [31:0]       slave_readdata,
  output logic              slave_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  input  logic              master_waitrequest
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_BIAS = 3'd1;
  localparam logic [2:0] S_RD_ACT  = 3'd2;
  localparam logic [2:0] S_RD_W    = 3'd3;
  localparam logic [2:0] S_WR_OUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [2:0]         state;
  logic [31:0]        w_base, in_base, bias_base, out_base, nlanes;
  logic [LEN_W-1:0]   len, k;
  logic [LEN_W:0]     k_next;
  logic [LW-1:0]      idx, n_last, mac_lane;
  logic signed [31:0] acc [LANES];
  logic [31:0]        act;
  logic [31:0]        prod_q;
  logic signed [63:0] prod_full;
  logic               rd_pend, done, mac_v, busy, start, rdv;
  logic [31:0]        rd_mux, res;
  logic [ADDR_W-1:0]  stride;
  logic               unused_prod;

  assign busy              = (state != S_IDLE) && (state != S_DONE);
  assign slave_waitrequest = slave_write && (state != S_IDLE);
  assign start             = slave_write && !slave_waitrequest && (slave_address == 3'd0);
  assign rdv               = master_readdatavalid && rd_pend;
  assign k_next            = {1'b0, k} + 1'b1;
  assign stride            = ADDR_W'({len, 2'b00});
  assign prod_full         = $signed(act) * $signed(master_readdata);
  assign unused_prod       = ^{prod_full[63:48], prod_full[15:0]};

  // Effective lane count: 0 or out-of-range NLANES means all lanes.
  always_comb begin
    n_last = LW'(LANES - 1);
    if (nlanes != 32'd0 && nlanes <= 32'(LANES))
      n_last = LW'(nlanes - 32'd1);
  end

  // Config register file; writes land only while idle (waitrequest holds them off).
  always_ff @(posedge clk) begin
    if (reset) begin
      w_base    <= '0;
      in_base   <= '0;
      bias_base <= '0;
      out_base  <= '0;
      len       <= '0;
      nlanes    <= '0;
    end else if (slave_write && !slave_waitrequest) begin
      case (slave_address)
        3'd1: w_base    <= slave_writedata;
        3'd2: in_base   <= slave_writedata;
        3'd3: bias_base <= slave_writedata;
        3'd4: out_base  <= slave_writedata;
        3'd5: len       <= slave_writedata[LEN_W-1:0];
        3'd6: nlanes    <= slave_writedata;
        default: ;
      endcase
    end
  end

  // Register read-back; never stalled.
  always_comb begin
    rd_mux = '0;
    case (slave_address)
      3'd0: rd_mux = {30'd0, done, busy};
      3'd1: rd_mux = w_base;
      3'd2: rd_mux = in_base;
      3'd3: rd_mux = bias_base;
      3'd4: rd_mux = out_base;
      3'd5: rd_mux = 32'(len);
      3'd6: rd_mux = nlanes;
      default: rd_mux = '0;
    endcase
    slave_readdata = slave_read ? rd_mux : 32'd0;
  end

  // Result path; the clamp is purely combinational so it adds no cycle.
  always_comb begin
    res = acc[idx];
`ifdef DNN_RELU_EN
    if (res[31]) res = '0;
`endif
    master_writedata = master_write ? res : 32'd0;
  end

  // Sequencer, master handshake and the two-stage MAC (product register, then accumulate).
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      master_read    <= 1'b0;
      master_write   <= 1'b0;
      master_address <= '0;
      rd_pend        <= 1'b0;
      done           <= 1'b0;
      mac_v          <= 1'b0;
      mac_lane       <= '0;
      prod_q         <= '0;
      act            <= '0;
      idx            <= '0;
      k              <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      mac_v <= 1'b0;
      if (mac_v) acc[mac_lane] <= acc[mac_lane] + $signed(prod_q);
      if (master_read && !master_waitrequest) begin
        master_read <= 1'b0;
        rd_pend     <= 1'b1;
      end
      if (rdv) rd_pend <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state          <= S_RD_BIAS;
          done           <= 1'b0;
          idx            <= '0;
          k              <= '0;
          master_read    <= 1'b1;
          master_address <= ADDR_W'(bias_base);
        end
        S_RD_BIAS: if (rdv) begin
          acc[idx] <= master_readdata;
          if (idx == n_last) begin
            idx <= '0;
            if (len == '0) begin
              state <= S_WR_OUT;
            end else begin
              state          <= S_RD_ACT;
              master_read    <= 1'b1;
              master_address <= ADDR_W'(in_base);
            end
          end else begin
            idx            <= idx + 1'b1;
            master_read    <= 1'b1;
            master_address <= master_address + ADDR_W'(4);
          end
        end
        S_RD_ACT: if (rdv) begin
          act            <= master_readdata;
          state          <= S_RD_W;
          idx            <= '0;
          master_read    <= 1'b1;
          master_address <= ADDR_W'(w_base) + (ADDR_W'(k) << 2);
        end
        S_RD_W: if (rdv) begin
          prod_q   <= prod_full[47:16];
          mac_lane <= idx;
          mac_v    <= 1'b1;
          if (idx == n_last) begin
            idx <= '0;
            if (k_next == {1'b0, len}) begin
              state <= S_WR_OUT;
            end else begin
              k              <= k_next[LEN_W-1:0];
              state          <= S_RD_ACT;
              master_read    <= 1'b1;
              master_address <= ADDR_W'(in_base) + (ADDR_W'(k_next) << 2);
            end
          end else begin
            idx            <= idx + 1'b1;
            master_read    <= 1'b1;
            master_address <= master_address + stride;
          end
        end
        // First cycle here lets the last MAC land before the first strobe.
        S_WR_OUT: if (!master_write) begin
          master_write   <= 1'b1;
          master_address <= ADDR_W'(out_base);
        end else if (!master_waitrequest) begin
          if (idx == n_last) begin
            master_write   <= 1'b0;
            master_address <= '0;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            idx            <= idx + 1'b1;
            master_address <= master_address + ADDR_W'(4);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
